// File: rtl/mem_access_unit.sv
// Load/store engine between the multicycle RV32 controller and a word-wide
// unified memory. It performs byte, half and word loads with sign or zero
// extension. Sub-word stores are done by read-modify-write of the full word.
// Completion is signalled by a one-cycle done pulse.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [2:0]            func3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  fault,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} state_t;

  state_t                state;
  logic [1:0]            a_lo;
  logic [2:0]            f3;
  logic [DATA_WIDTH-1:0] wd;
  logic                  st;

  logic                  bad;
  logic [7:0]            bsel;
  logic [15:0]           hsel;
  logic [DATA_WIDTH-1:0] load_val;
  logic [DATA_WIDTH-1:0] merged;

  // Request decode: illegal func3 for the direction, or misaligned half/word
  always_comb begin
    bad = 1'b0;
    if (we)
      bad = !(func3 == 3'b000 || func3 == 3'b001 || func3 == 3'b010);
    else
      bad = (func3 == 3'b011 || func3[2:1] == 2'b11);
    if (func3[1:0] == 2'b01 && addr[0])
      bad = 1'b1;
    if (func3[1:0] == 2'b10 && addr[1:0] != 2'b00)
      bad = 1'b1;
  end

  // Little-endian lane extraction and extension of the returned word
  always_comb begin
    bsel = mem_rdata[{a_lo, 3'b000} +: 8];
    hsel = mem_rdata[{a_lo[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  load_val = {{(DATA_WIDTH-8){bsel[7]}}, bsel};
      3'b100:  load_val = {{(DATA_WIDTH-8){1'b0}}, bsel};
      3'b001:  load_val = {{(DATA_WIDTH-16){hsel[15]}}, hsel};
      3'b101:  load_val = {{(DATA_WIDTH-16){1'b0}}, hsel};
      default: load_val = mem_rdata;
    endcase
  end

  // Sub-word store merge into the word just read
  always_comb begin
    merged = mem_rdata;
    if (f3[0])
      merged[{a_lo[1], 4'b0000} +: 16] = wd[15:0];
    else
      merged[{a_lo, 3'b000} +: 8] = wd[7:0];
  end

  // Access sequencer with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      a_lo      <= '0;
      f3        <= '0;
      wd        <= '0;
      st        <= 1'b0;
      rdata     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          done  <= 1'b0;
          fault <= 1'b0;
          if (req) begin
            a_lo <= addr[1:0];
            f3   <= func3;
            wd   <= wdata;
            st   <= we;
            busy <= 1'b1;
            if (bad) begin
              state <= FIN;
              done  <= 1'b1;
              fault <= 1'b1;
            end else if (!we || func3 != 3'b010) begin
              state    <= READ;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= {addr[ADDR_WIDTH-1:2], 2'b00};
            end else begin
              state     <= WRITE;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
              mem_wdata <= wdata;
            end
          end
        end
        READ: begin
          if (mem_ack) begin
            if (st) begin
              // mem_req stays high straight into the write phase
              state     <= WRITE;
              mem_we    <= 1'b1;
              mem_wdata <= merged;
            end else begin
              state   <= FIN;
              rdata   <= load_val;
              mem_req <= 1'b0;
              done    <= 1'b1;
              fault   <= 1'b0;
            end
          end
        end
        WRITE: begin
          if (mem_ack) begin
            state   <= FIN;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            fault   <= 1'b0;
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
          fault <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
